dec_vtp_ctrl: RTL and testbench
===============================

// Module: dec_vtp_ctrl
// PURPOSE
//  Shares one dec_vtp translation datapath (OREG_EN=1) between NREQ lookup requesters.
//  Owns the SCB configuration: a shadow bank written row-by-row, and an active bank that drives dec_vtp.
//  Commits shadow->active atomically after draining in-flight lookups.
//  Sits between the page allocator (config/commit) and the translation clients.
// PARAMETERS
//  BITMAP  128  pages managed; ADDR_W=$clog2(BITMAP), STAGES=$clog2(BITMAP), NODES=BITMAP/2
//  NREQ    4    number of lookup requesters (>=2); ID_W=$clog2(NREQ)
// PORTS
//  i_clk          in   1            clock
//  i_rst          in   1            reset, asynchronous, active-high
//  i_req_valid    in   NREQ         per-requester lookup request
//  i_req_vaddr    in   NREQ*ADDR_W  requester k vaddr at [k*ADDR_W +: ADDR_W]
//  o_req_ready    out  NREQ         one-hot grant; handshake when valid&ready
//  o_rsp_valid    out  1            translation result valid (no backpressure)
//  o_rsp_id       out  ID_W         requester index of result
//  o_rsp_paddr    out  ADDR_W       physical address
//  i_cfg_we       in   1            write one shadow SCB row
//  i_cfg_stage    in   ADDR_W       row (stage) index; >=STAGES ignored
//  i_cfg_data     in   NODES        row data
//  i_commit       in   1            request shadow->active swap
//  o_commit_done  out  1            1-cycle pulse: swap completed
//  o_busy         out  1            commit in progress
// BEHAVIOUR
//  - Reset: both banks all-zero (identity map, paddr=vaddr); RR pointer=0; FSM=IDLE;
//    all outputs 0 (perf counters 0).
//  - Arbitration: round-robin from pointer; o_req_ready = grant, combinational from i_req_valid.
//    Pointer -> (granted+1)%NREQ on grant; unchanged when no grant. Max one grant/cycle.
//  - Pipeline: grant cycle N -> vaddr+id registered N+1 -> dec_vtp output register -> o_rsp_* at N+2.
//    Throughput 1 lookup/cycle. o_rsp_id/o_rsp_paddr hold last value when o_rsp_valid=0.
//  - dec_vtp i_scb fed from active bank only; the shadow bank never affects lookups.
//  - Config: i_cfg_we writes shadow[i_cfg_stage] in any FSM state.
//  - FSM IDLE: grants enabled; i_commit -> DRAIN.
//  - FSM DRAIN: o_busy=1; no grants (o_req_ready=0); both pipeline valids 0 -> SWAP.
//  - FSM SWAP: o_busy=1, no grants; active<=shadow (shadow value at start of cycle); -> IDLE.
//    o_commit_done=1 in the first IDLE cycle after SWAP.
//  - i_commit in the same cycle as a grant: that grant is honoured, DRAIN entered next cycle.
//  - Empty pipeline: DRAIN lasts 1 cycle. Full pipeline: DRAIN lasts 2 cycles.
//  - i_commit while o_busy=1 is ignored; there is no commit queue.
//  - A cfg write in the SWAP cycle lands in shadow only and is not part of that swap.
//  - Reset mid-DRAIN/SWAP: aborts to IDLE; both banks are zeroed; no o_commit_done.
// CONFIGURATION
//  DEC_VTP_CTRL_PERF_EN defined:
//  - adds o_perf_lookups[31:0] (+1 per handshake) and o_perf_stall[31:0]
//    (+1 per cycle with |i_req_valid and no grant).
//  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
//  DEC_VTP_CTRL_PERF_EN undefined: these ports and the counter logic are absent.
// TESTING
//  1 Reset, then req0 vaddr=7'h35 -> ready0 same cycle; rsp_valid 2 cycles later with id=0, paddr=7'h35.
//  2 All 4 valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; one rsp per cycle in order.
//  3 Req1 and req2 granted back-to-back, commit raised with req2 grant
//    -> ready=0 for 3 cycles (DRAIN x2, SWAP); done pulse follows; both rsp use the old map.
//  4 Write shadow row 6 = all-ones, no commit -> lookups unchanged; after commit,
//    lookup of 0 returns new map (MSB flips per dec_vtp).
//  5 cfg_we with stage=7 (STAGES=7) -> no effect after commit; commit pulsed while busy
//    -> exactly one commit_done.
//  6 Assert i_rst during DRAIN -> outputs 0 immediately; next lookup is identity; no commit_done.

Source files
------------

// File: rtl/dec_vtp_ctrl.sv
// dec_vtp_ctrl: round-robin front end for a shared dec_vtp translation datapath.
// The translation itself is a butterfly of STAGES switch rows. At stage s the
// node index is the address with bit s removed, and a set switch bit flips
// address bit s. This makes every configuration a permutation, and the all-zero
// configuration is the identity map. The datapath has an output register.
// Lookups only ever see the active SCB bank. The page allocator fills a shadow
// bank row by row, and a commit swaps it in once in-flight lookups have drained.
// Optional feature: define DEC_VTP_CTRL_PERF_EN to add saturating counters for
// lookups and stalls.
module dec_vtp_ctrl #(
  parameter int BITMAP = 128,
  parameter int NREQ   = 4,
  localparam int ADDR_W = $clog2(BITMAP),
  localparam int STAGES = $clog2(BITMAP),
  localparam int NODES  = BITMAP / 2,
  localparam int ID_W   = $clog2(NREQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NREQ-1:0]        i_req_valid,
  input  logic [NREQ*ADDR_W-1:0] i_req_vaddr,
  output logic [NREQ-1:0]        o_req_ready,
  output logic                   o_rsp_valid,
  output logic [ID_W-1:0]        o_rsp_id,
  output logic [ADDR_W-1:0]      o_rsp_paddr,
  input  logic                   i_cfg_we,
  input  logic [ADDR_W-1:0]      i_cfg_stage,
  input  logic [NODES-1:0]       i_cfg_data,
  input  logic                   i_commit,
  output logic                   o_commit_done,
`ifdef DEC_VTP_CTRL_PERF_EN
  output logic [31:0]            o_perf_lookups,
  output logic [31:0]            o_perf_stall,
`endif
  output logic                   o_busy
);

  localparam int NODE_W = ADDR_W - 1;

  typedef enum logic [1:0] {IDLE, DRAIN, SWAP} state_t;

  state_t              state_reg, state_next;
  logic [ID_W-1:0]     rr_ptr_reg;
  logic [NREQ-1:0]     grant;
  logic                grant_any;
  logic [ID_W-1:0]     grant_id;
  logic [ADDR_W-1:0]   grant_vaddr;
  logic                s1_valid_reg;
  logic [ID_W-1:0]     s1_id_reg;
  logic [ADDR_W-1:0]   s1_vaddr_reg;
  logic                rsp_valid_reg;
  logic [ID_W-1:0]     rsp_id_reg;
  logic [ADDR_W-1:0]   rsp_paddr_reg;
  logic                done_reg;
  logic [ADDR_W-1:0]   xlat;
  logic [NODE_W-1:0]   node;
  logic [NODES-1:0]    shadow_reg [STAGES];
  logic [NODES-1:0]    active_reg [STAGES];

  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] ptr, input int ofs);
    return ID_W'((int'(ptr) + ofs) % NREQ);
  endfunction

  // Round-robin grant starting at the pointer; no grants outside IDLE or during reset.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    if (state_reg == IDLE && !i_rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_any && i_req_valid[rr_index(rr_ptr_reg, i)]) begin
          grant[rr_index(rr_ptr_reg, i)] = 1'b1;
          grant_id  = rr_index(rr_ptr_reg, i);
          grant_any = 1'b1;
        end
      end
    end
  end

  // Select the granted requester's vaddr.
  always_comb begin
    grant_vaddr = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) grant_vaddr = i_req_vaddr[k*ADDR_W +: ADDR_W];
    end
  end

  // Pointer moves just past the winner, so that requester has lowest priority next.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rr_ptr_reg <= '0;
    else if (grant_any) rr_ptr_reg <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
  end

  // Stage 1: capture the granted lookup.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_reg <= 1'b0;
      s1_id_reg    <= '0;
      s1_vaddr_reg <= '0;
    end else begin
      s1_valid_reg <= grant_any;
      if (grant_any) begin
        s1_id_reg    <= grant_id;
        s1_vaddr_reg <= grant_vaddr;
      end
    end
  end

  // Butterfly translation through the active bank.
  always_comb begin
    xlat = s1_vaddr_reg;
    node = '0;
    for (int s = 0; s < STAGES; s++) begin
      node    = NODE_W'(((xlat >> (s + 1)) << s) | (xlat & ((ADDR_W'(1) << s) - ADDR_W'(1))));
      xlat[s] = xlat[s] ^ active_reg[s][node];
    end
  end

  // Output register; id/paddr hold their last value while no result is valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_paddr_reg <= '0;
    end else begin
      rsp_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        rsp_id_reg    <= s1_id_reg;
        rsp_paddr_reg <= xlat;
      end
    end
  end

  // Commit FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_reg <= IDLE;
    else state_reg <= state_next;
  end

  // Commit FSM next state. Only the stage-1 lookup still reads the active bank,
  // so the swap may proceed once it is empty, even with a result in the output register.
  always_comb begin
    state_next = state_reg;
    o_busy     = 1'b1;
    case (state_reg)
      IDLE: begin
        o_busy = 1'b0;
        if (i_commit) state_next = DRAIN;
      end
      DRAIN:   if (!s1_valid_reg && !grant_any) state_next = SWAP;
      SWAP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Completion pulse in the first IDLE cycle after the swap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) done_reg <= 1'b0;
    else done_reg <= (state_reg == SWAP);
  end

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_row
      // Shadow row: written by the allocator in any state; out-of-range stages never match.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) shadow_reg[gi] <= '0;
        else if (i_cfg_we && i_cfg_stage == ADDR_W'(gi)) shadow_reg[gi] <= i_cfg_data;
      end

      // Active row: takes the shadow value as it stood at the start of the SWAP cycle.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) active_reg[gi] <= '0;
        else if (state_reg == SWAP) active_reg[gi] <= shadow_reg[gi];
      end
    end
  endgenerate

`ifdef DEC_VTP_CTRL_PERF_EN
  // Saturating counters: handshakes, and cycles with a request pending but no grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_perf_lookups <= '0;
      o_perf_stall   <= '0;
    end else begin
      if (grant_any && o_perf_lookups != 32'hFFFF_FFFF)
        o_perf_lookups <= o_perf_lookups + 32'd1;
      if ((|i_req_valid) && !grant_any && o_perf_stall != 32'hFFFF_FFFF)
        o_perf_stall <= o_perf_stall + 32'd1;
    end
  end
`endif

  assign o_req_ready   = grant;
  assign o_rsp_valid   = rsp_valid_reg;
  assign o_rsp_id      = rsp_id_reg;
  assign o_rsp_paddr   = rsp_paddr_reg;
  assign o_commit_done = done_reg;

endmodule

// File: tb/tb_dec_vtp_ctrl.sv
// Testbench for dec_vtp_ctrl (default build, DEC_VTP_CTRL_PERF_EN undefined).
// Scoreboard: expected {id, paddr} pushed at each handshake from a reference
// butterfly model, popped when a result appears.
module tb_dec_vtp_ctrl;
  localparam int BITMAP = 128;
  localparam int NREQ   = 4;
  localparam int ADDR_W = 7;
  localparam int STAGES = 7;
  localparam int NODES  = 64;
  localparam int ID_W   = 2;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] paddr;
  } exp_t;

  logic                   i_clk;
  logic                   i_rst;
  logic [NREQ-1:0]        i_req_valid;
  logic [NREQ*ADDR_W-1:0] i_req_vaddr;
  logic [NREQ-1:0]        o_req_ready;
  logic                   o_rsp_valid;
  logic [ID_W-1:0]        o_rsp_id;
  logic [ADDR_W-1:0]      o_rsp_paddr;
  logic                   i_cfg_we;
  logic [ADDR_W-1:0]      i_cfg_stage;
  logic [NODES-1:0]       i_cfg_data;
  logic                   i_commit;
  logic                   o_commit_done;
  logic                   o_busy;

  int   passed = 0;
  int   total  = 0;
  bit   mon_en = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [NODES-1:0] mdl_shadow [STAGES];
  logic [NODES-1:0] mdl_active [STAGES];

  dec_vtp_ctrl #(.BITMAP(BITMAP), .NREQ(NREQ)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .i_req_vaddr(i_req_vaddr), .o_req_ready(o_req_ready),
    .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_paddr(o_rsp_paddr),
    .i_cfg_we(i_cfg_we), .i_cfg_stage(i_cfg_stage), .i_cfg_data(i_cfg_data),
    .i_commit(i_commit), .o_commit_done(o_commit_done), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Reference butterfly: node = address with bit s removed; set switch flips bit s.
  function automatic logic [ADDR_W-1:0] model_xlat(input logic [ADDR_W-1:0] va);
    int a;
    int lo;
    int hi;
    int nd;
    a = int'(va);
    for (int s = 0; s < STAGES; s++) begin
      lo = a % (1 << s);
      hi = a >> (s + 1);
      nd = hi * (1 << s) + lo;
      if (mdl_active[s][nd]) a = a ^ (1 << s);
    end
    return ADDR_W'(a);
  endfunction

  always @(negedge i_clk) begin
    if (mon_en && !i_rst) begin
      if (o_rsp_valid) begin
        total++;
        if (sb.size() == 0) begin
          $display("FAIL rsp_unexpected: got id=%0d paddr=%h, expected no response", o_rsp_id, o_rsp_paddr);
        end else begin
          mon_e = sb.pop_front();
          if (o_rsp_id !== mon_e.id || o_rsp_paddr !== mon_e.paddr)
            $display("FAIL rsp_data: got id=%0d paddr=%h, expected id=%0d paddr=%h",
                     o_rsp_id, o_rsp_paddr, mon_e.id, mon_e.paddr);
          else begin
            passed++;
            $display("rsp id=%0d paddr=%h ok", o_rsp_id, o_rsp_paddr);
          end
        end
      end
      for (int k = 0; k < NREQ; k++) begin
        if (i_req_valid[k] && o_req_ready[k])
          sb.push_back('{id: ID_W'(k), paddr: model_xlat(i_req_vaddr[k*ADDR_W +: ADDR_W])});
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 0;
    i_rst = 1'b1;
    i_req_valid = '0;
    i_req_vaddr = '0;
    i_cfg_we = 1'b0;
    i_cfg_stage = '0;
    i_cfg_data = '0;
    i_commit = 1'b0;
    sb.delete();
    for (int s = 0; s < STAGES; s++) begin
      mdl_shadow[s] = '0;
      mdl_active[s] = '0;
    end
    step();
    step();
    i_rst = 1'b0;
    mon_en = 1;
  endtask

  task automatic cfg_write(input int stage, input logic [NODES-1:0] data);
    step();
    i_cfg_we = 1'b1;
    i_cfg_stage = ADDR_W'(stage);
    i_cfg_data = data;
    if (stage < STAGES) mdl_shadow[stage] = data;
    step();
    i_cfg_we = 1'b0;
  endtask

  task automatic do_lookup(input int k, input logic [ADDR_W-1:0] va,
                           output logic [ADDR_W-1:0] pa, output bit ok);
    ok = 0;
    pa = '0;
    step();
    i_req_vaddr[k*ADDR_W +: ADDR_W] = va;
    i_req_valid = NREQ'(1) << k;
    step();
    i_req_valid = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      if (o_rsp_valid && !ok) begin
        pa = o_rsp_paddr;
        ok = 1;
      end
    end
  endtask

  // Raise commit for one cycle and count done pulses over a bounded window.
  task automatic commit_and_count(output int ndone);
    ndone = 0;
    step();
    i_commit = 1'b1;
    step();
    i_commit = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      if (o_commit_done) ndone++;
    end
    for (int s = 0; s < STAGES; s++) mdl_active[s] = mdl_shadow[s];
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    mon_en = 0;
    i_req_valid = 4'b1111;
    i_req_vaddr = '0;
    i_cfg_we = 1'b0;
    i_cfg_stage = '0;
    i_cfg_data = '0;
    i_commit = 1'b0;
    for (int s = 0; s < STAGES; s++) begin
      mdl_shadow[s] = '0;
      mdl_active[s] = '0;
    end
    @(negedge i_clk);
    @(negedge i_clk);
    total++;
    if ({o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_paddr, o_commit_done, o_busy} !== '0)
      $display("FAIL reset_outputs: got ready=%b rv=%b id=%0d pa=%h done=%b busy=%b, expected all 0",
               o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_paddr, o_commit_done, o_busy);
    else begin passed++; $display("reset outputs ok"); end
    step();
    i_rst = 1'b0;
    i_req_valid = '0;
    mon_en = 1;
    step();
    i_req_vaddr[0 +: ADDR_W] = 7'h35;
    i_req_valid = 4'b0001;
    @(negedge i_clk);
    total++;
    if (o_req_ready !== 4'b0001)
      $display("FAIL first_grant: got ready=%b, expected 0001", o_req_ready);
    else begin passed++; $display("first grant ok"); end
    step();
    i_req_valid = '0;
    @(negedge i_clk);
    total++;
    if (o_rsp_valid !== 1'b0)
      $display("FAIL latency_early: got rsp_valid=%b at N+1, expected 0", o_rsp_valid);
    else passed++;
    @(negedge i_clk);
    total++;
    if (o_rsp_valid !== 1'b1 || o_rsp_id !== 2'd0 || o_rsp_paddr !== 7'h35)
      $display("FAIL latency_n2: got rv=%b id=%0d pa=%h, expected rv=1 id=0 pa=35",
               o_rsp_valid, o_rsp_id, o_rsp_paddr);
    else begin passed++; $display("lookup 35 -> 35 at N+2 ok"); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      step();
      i_req_vaddr = (NREQ*ADDR_W)'($urandom);
      i_req_valid = 4'b1111;
      @(negedge i_clk);
      total++;
      if (o_req_ready !== (4'b0001 << (c % 4)))
        $display("FAIL rr_grant%0d: got ready=%b, expected %b", c, o_req_ready, 4'b0001 << (c % 4));
      else begin passed++; $display("rr cycle %0d grant=%b ok", c, o_req_ready); end
    end
    step();
    i_req_valid = '0;
    repeat (3) @(negedge i_clk);
    total++;
    if (sb.size() != 0)
      $display("FAIL rr_drained: got %0d pending responses, expected 0", sb.size());
    else passed++;
  endtask

  task automatic test_commit_drain();
    do_reset();
    cfg_write(0, '1);
    step();
    i_req_vaddr[1*ADDR_W +: ADDR_W] = 7'h12;
    i_req_valid = 4'b0010;
    @(negedge i_clk);
    total++;
    if (o_req_ready !== 4'b0010) $display("FAIL drain_g1: got ready=%b, expected 0010", o_req_ready);
    else passed++;
    step();
    i_req_vaddr[2*ADDR_W +: ADDR_W] = 7'h2b;
    i_req_valid = 4'b0100;
    i_commit = 1'b1;
    @(negedge i_clk);
    total++;
    if (o_req_ready !== 4'b0100 || o_busy !== 1'b0)
      $display("FAIL drain_g2: got ready=%b busy=%b, expected 0100 busy=0", o_req_ready, o_busy);
    else passed++;
    for (int c = 0; c < 3; c++) begin
      step();
      i_commit = 1'b0;
      i_req_valid = 4'b1111;
      @(negedge i_clk);
      total++;
      if (o_req_ready !== 4'b0000 || o_busy !== 1'b1 || o_commit_done !== 1'b0)
        $display("FAIL drain_block%0d: got ready=%b busy=%b done=%b, expected 0000 1 0",
                 c, o_req_ready, o_busy, o_commit_done);
      else begin passed++; $display("drain cycle %0d blocked ok", c); end
    end
    step();
    for (int s = 0; s < STAGES; s++) mdl_active[s] = mdl_shadow[s];
    @(negedge i_clk);
    total++;
    if (o_commit_done !== 1'b1 || o_busy !== 1'b0 || o_req_ready !== 4'b1000)
      $display("FAIL drain_done: got done=%b busy=%b ready=%b, expected 1 0 1000",
               o_commit_done, o_busy, o_req_ready);
    else begin passed++; $display("commit done pulse ok"); end
    step();
    i_req_valid = '0;
    @(negedge i_clk);
    total++;
    if (o_commit_done !== 1'b0) $display("FAIL done_width: got done=%b, expected 0", o_commit_done);
    else passed++;
    repeat (3) @(negedge i_clk);
  endtask

  task automatic test_shadow_isolation();
    logic [ADDR_W-1:0] pa;
    bit ok;
    int nd;
    do_reset();
    cfg_write(6, '1);
    do_lookup(0, 7'h00, pa, ok);
    total++;
    if (!ok || pa !== 7'h00) $display("FAIL shadow_isolated: got ok=%b pa=%h, expected 00", ok, pa);
    else begin passed++; $display("shadow write invisible ok"); end
    commit_and_count(nd);
    total++;
    if (nd != 1) $display("FAIL commit_once: got %0d done pulses, expected 1", nd);
    else passed++;
    do_lookup(0, 7'h00, pa, ok);
    total++;
    if (!ok || pa !== 7'h40) $display("FAIL new_map: got ok=%b pa=%h, expected 40", ok, pa);
    else begin passed++; $display("lookup 00 -> 40 after commit ok"); end
  endtask

  task automatic test_commit_busy();
    logic [ADDR_W-1:0] pa;
    bit ok;
    int nd;
    do_reset();
    cfg_write(7, '1);
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      i_commit = (c == 0 || c == 2);
      i_cfg_we = (c == 2);
      i_cfg_stage = 7'd1;
      i_cfg_data = '1;
      if (c == 2) begin
        for (int s = 0; s < STAGES; s++) mdl_active[s] = mdl_shadow[s];
        mdl_shadow[1] = '1;
      end
      @(negedge i_clk);
      if (c == 2) begin
        total++;
        if (o_busy !== 1'b1) $display("FAIL busy_swap: got busy=%b, expected 1", o_busy);
        else passed++;
      end
      if (o_commit_done) nd++;
    end
    i_commit = 1'b0;
    i_cfg_we = 1'b0;
    total++;
    if (nd != 1) $display("FAIL busy_commit: got %0d done pulses, expected 1", nd);
    else begin passed++; $display("commit while busy ignored ok"); end
    do_lookup(3, 7'h55, pa, ok);
    total++;
    if (!ok || pa !== 7'h55) $display("FAIL stage7_swapcfg: got ok=%b pa=%h, expected 55", ok, pa);
    else passed++;
    commit_and_count(nd);
    do_lookup(3, 7'h55, pa, ok);
    total++;
    if (!ok || pa !== 7'h57) $display("FAIL swapcycle_cfg_later: got ok=%b pa=%h, expected 57", ok, pa);
    else begin passed++; $display("swap-cycle cfg applied on next commit ok"); end
  endtask

  task automatic test_reset_drain();
    logic [ADDR_W-1:0] pa;
    bit ok;
    int nd;
    do_reset();
    cfg_write(0, '1);
    step();
    i_req_vaddr[0 +: ADDR_W] = 7'h11;
    i_req_valid = 4'b0001;
    step();
    i_req_vaddr[1*ADDR_W +: ADDR_W] = 7'h22;
    i_req_valid = 4'b0010;
    i_commit = 1'b1;
    step();
    i_req_valid = 4'b1111;
    i_commit = 1'b0;
    #1;
    total++;
    if (o_busy !== 1'b1 || o_rsp_valid !== 1'b1)
      $display("FAIL pre_abort: got busy=%b rv=%b, expected 1 1", o_busy, o_rsp_valid);
    else passed++;
    mon_en = 0;
    i_rst = 1'b1;
    #1;
    total++;
    if ({o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_paddr, o_commit_done, o_busy} !== '0)
      $display("FAIL abort_outputs: got ready=%b rv=%b id=%0d pa=%h done=%b busy=%b, expected all 0",
               o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_paddr, o_commit_done, o_busy);
    else begin passed++; $display("async reset in drain ok"); end
    sb.delete();
    for (int s = 0; s < STAGES; s++) begin
      mdl_shadow[s] = '0;
      mdl_active[s] = '0;
    end
    step();
    i_rst = 1'b0;
    i_req_valid = '0;
    mon_en = 1;
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      if (o_commit_done) nd++;
    end
    total++;
    if (nd != 0) $display("FAIL abort_no_done: got %0d done pulses, expected 0", nd);
    else passed++;
    do_lookup(0, 7'h2c, pa, ok);
    total++;
    if (!ok || pa !== 7'h2c) $display("FAIL abort_identity: got ok=%b pa=%h, expected 2c", ok, pa);
    else passed++;
    commit_and_count(nd);
    do_lookup(2, 7'h2c, pa, ok);
    total++;
    if (!ok || pa !== 7'h2c) $display("FAIL shadow_zeroed: got ok=%b pa=%h, expected 2c", ok, pa);
    else begin passed++; $display("shadow zeroed by reset ok"); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_commit_drain();
    test_shadow_isolation();
    test_commit_busy();
    test_reset_drain();
    repeat (3) @(negedge i_clk);
    total++;
    if (sb.size() != 0) $display("FAIL sb_empty: got %0d pending responses, expected 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
